matrix_mac_sequencer: RTL and testbench

Control and operand-feeding side of the multiply-accumulate datapath. On start, it computes C = A×B, or C = −(A×B) when subtract mode is selected, for N×N signed matrices held in external synchronous-read memories. For each product it drives the external arithmetic unit with both operands and the running accumulator, then captures the unit's result. Each finished C element is written to the result memory, and the unit's per-cycle error flag is folded into one sticky per-job error.

---
 rtl/matrix_mac_sequencer_pkg.sv | 31 +++
 rtl/matrix_index_gen.sv | 76 +++++++
 rtl/matrix_mac_sequencer.sv | 151 +++++++++++++++
 tb/tb_matrix_mac_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mac_sequencer_pkg.sv
// Shared definitions for the matrix multiply-accumulate sequencer.
// Holds the FSM state encoding and the default datapath geometry, which
// the external arithmetic unit also uses so both sides agree on widths.
package matrix_mac_sequencer_pkg;

    // Element/accumulator width shared with the arithmetic unit
    localparam int WIDTH_DEF = 8;

    // Matrix dimension (N x N)
    localparam int N_DEF = 4;

    // Memory address width; 2**ADDRW_DEF must cover N_DEF*N_DEF elements
    localparam int ADDRW_DEF = 4;

    // Sequencer states; the numeric encoding is fixed so that the state can
    // be matched against waveforms and against the arithmetic unit's docs
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_ACC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit so that a
    // degenerate 1x1 matrix still gets a legal counter declaration
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_index_gen.sv
// Index and address generator for the matrix sequencer.
// Keeps the row (i), column (j) and inner-product (k) counters, reports when
// each sits on its last value, and forms the row-major addresses for the
// A, B and C memories from them.
module matrix_index_gen
    import matrix_mac_sequencer_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int AddrW = ADDRW_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_stepK,
    input  logic             i_stepIJ,
    output logic             o_kLast,
    output logic             o_jLast,
    output logic             o_iLast,
    output logic [AddrW-1:0] o_aAddr,
    output logic [AddrW-1:0] o_bAddr,
    output logic [AddrW-1:0] o_cAddr
);

    localparam int             IdxW    = idxWidth(N);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    logic [IdxW-1:0] r_i;
    logic [IdxW-1:0] r_j;
    logic [IdxW-1:0] r_k;

    logic w_kLast;
    logic w_jLast;
    logic w_iLast;

    assign w_kLast = (r_k == LastIdx);
    assign w_jLast = (r_j == LastIdx);
    assign w_iLast = (r_i == LastIdx);

    // Counter update: k advances once per product, i/j advance once per
    // finished element (j fastest), and a new job clears all three
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_clear) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else begin
            if (i_stepK) begin
                r_k <= w_kLast ? '0 : r_k + 1'b1;
            end
            if (i_stepIJ) begin
                if (w_jLast) begin
                    r_j <= '0;
                    r_i <= w_iLast ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

    assign o_kLast = w_kLast;
    assign o_jLast = w_jLast;
    assign o_iLast = w_iLast;

    // Row-major addresses. With a power-of-two N the multiply collapses to a
    // shift; for other N it is a small constant multiply. All terms come
    // straight from registers, so the addresses behave as registered outputs.
    assign o_aAddr = AddrW'(r_i) * AddrW'(N) + AddrW'(r_k);
    assign o_bAddr = AddrW'(r_k) * AddrW'(N) + AddrW'(r_j);
    assign o_cAddr = AddrW'(r_i) * AddrW'(N) + AddrW'(r_j);

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Control and operand-feeding side of the matrix multiply-accumulate path.
// Computes C = A*B (or C = -(A*B) in subtract mode) one element at a time:
// for every inner-product step it reads A and B, hands them plus the running
// accumulator to the external arithmetic unit, and captures the result.
// Each finished element is written to the C memory; the unit's overflow flag
// is folded into a sticky per-job error.
module matrix_mac_sequencer
    import matrix_mac_sequencer_pkg::*;
#(
    parameter int Width = WIDTH_DEF,
    parameter int N     = N_DEF,
    parameter int AddrW = ADDRW_DEF
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    output logic             busy,
    output logic             done,
    output logic [AddrW-1:0] a_addr,
    output logic [AddrW-1:0] b_addr,
    input  logic [Width-1:0] a_data,
    input  logic [Width-1:0] b_data,
    output logic [Width-1:0] mac_a,
    output logic [Width-1:0] mac_b,
    output logic [Width-1:0] mac_c,
    output logic             mac_op,
    input  logic [Width-1:0] mac_out,
    input  logic             mac_err,
    output logic [AddrW-1:0] c_addr,
    output logic [Width-1:0] c_data,
    output logic             c_we,
    output logic             error
);

    state_t r_state;

    logic [Width-1:0] r_acc;
    logic             r_op;
    logic             r_busy;
    logic             r_done;
    logic             r_we;
    logic             r_error;

    logic w_clear;
    logic w_stepK;
    logic w_stepIJ;
    logic w_kLast;
    logic w_jLast;
    logic w_iLast;

    // The counters only move in response to the registered state, so start
    // reaches the outputs only through flops
    assign w_clear  = (r_state == ST_IDLE) && start;
    assign w_stepK  = (r_state == ST_ACC);
    assign w_stepIJ = (r_state == ST_WRITE);

    matrix_index_gen #(
        .N     (N),
        .AddrW (AddrW)
    ) u_indexGen (
        .i_clk    (CLK),
        .i_rst_n  (reset),
        .i_clear  (w_clear),
        .i_stepK  (w_stepK),
        .i_stepIJ (w_stepIJ),
        .o_kLast  (w_kLast),
        .o_jLast  (w_jLast),
        .o_iLast  (w_iLast),
        .o_aAddr  (a_addr),
        .o_bAddr  (b_addr),
        .o_cAddr  (c_addr)
    );

    // Sequencer FSM: walks READ/ACC pairs for every k, then one WRITE per
    // element, and produces the registered busy/done/write/error outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_op    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= op_sub;
                        r_acc   <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_ACC;
                end
                ST_ACC: begin
                    r_acc <= mac_out;
                    if (mac_err) begin
                        r_error <= 1'b1;
                    end
                    if (w_kLast) begin
                        r_we    <= 1'b1;
                        r_state <= ST_WRITE;
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    r_we  <= 1'b0;
                    r_acc <= '0;
                    if (w_jLast && w_iLast) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operands pass straight from the memories; they only matter during ACC
    assign mac_a  = a_data;
    assign mac_b  = b_data;
    assign mac_c  = r_acc;
    assign mac_op = r_op;

    // The accumulator is written out unchanged during WRITE
    assign c_data = r_acc;
    assign c_we   = r_we;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Self-checking bench for matrix_mac_sequencer.
// Provides synchronous-read A/B memories, a capturing C memory and a
// behavioural arithmetic unit, and compares the sequencer every cycle against
// a job-level model derived from plain matrix arithmetic and cycle timing.
module tb_matrix_mac_sequencer;

    localparam int W          = 8;
    localparam int N          = 4;
    localparam int AW         = 4;
    localparam int NN         = N * N;
    localparam int ElemCycles = 2 * N + 1;
    localparam int JobCycles  = NN * ElemCycles;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          op_sub = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [W-1:0]  a_data;
    logic [W-1:0]  b_data;
    logic [W-1:0]  mac_a;
    logic [W-1:0]  mac_b;
    logic [W-1:0]  mac_c;
    logic          mac_op;
    logic [W-1:0]  mac_out;
    logic          mac_err;
    logic [AW-1:0] c_addr;
    logic [W-1:0]  c_data;
    logic          c_we;
    logic          error;

    matrix_mac_sequencer #(
        .Width (W),
        .N     (N),
        .AddrW (AW)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .op_sub  (op_sub),
        .busy    (busy),
        .done    (done),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .a_data  (a_data),
        .b_data  (b_data),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_c   (mac_c),
        .mac_op  (mac_op),
        .mac_out (mac_out),
        .mac_err (mac_err),
        .c_addr  (c_addr),
        .c_data  (c_data),
        .c_we    (c_we),
        .error   (error)
    );

    always #5 CLK = ~CLK;

    int passCount = 0;
    int checkCount = 0;
    int cyc = 0;
    int weCount = 0;

    logic [W-1:0] aMem [NN];
    logic [W-1:0] bMem [NN];
    logic [W-1:0] cMem [NN];
    logic [W-1:0] aQ = '0;
    logic [W-1:0] bQ = '0;

    // Job-level model state
    int   expC [NN];
    int   partial [NN][N];
    int   errCycle = -1;
    int   jobStart = 0;
    logic jobActive = 1'b0;
    logic jobOp = 1'b0;
    logic errPrev = 1'b0;

    // Cycle counter: one tick per rising edge
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Synchronous-read A/B memories and the capturing C memory
    always @(posedge CLK) begin
        aQ <= aMem[a_addr];
        bQ <= bMem[b_addr];
        if (c_we) begin
            cMem[c_addr] <= c_data;
            weCount      <= weCount + 1;
        end
    end

    assign a_data = aQ;
    assign b_data = bQ;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int wrap8(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    // Behavioural arithmetic unit: exact result, then wrapped output and
    // an overflow flag when the exact value does not fit in W signed bits
    function automatic int macFull(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] c, input logic op);
        int p;
        p = sx(a) * sx(b);
        return op ? sx(c) - p : sx(c) + p;
    endfunction

    int macFullV;
    assign macFullV = macFull(mac_a, mac_b, mac_c, mac_op);
    assign mac_out  = macFullV[W-1:0];
    assign mac_err  = (macFullV > 127) || (macFullV < -128);

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: C element e = sum over k of +/- A[i][k]*B[k][j], wrapped per
    // step; records the running value before each step and the first
    // overflowing step as the cycle (relative to start) error must show 1
    task automatic computeModel(input logic op);
        int ii;
        int jj;
        int acc;
        int p;
        int full;
        errCycle = -1;
        for (int e = 0; e < NN; e++) begin
            ii  = e / N;
            jj  = e % N;
            acc = 0;
            for (int k = 0; k < N; k++) begin
                partial[e][k] = acc;
                p    = sx(aMem[ii * N + k]) * sx(bMem[k * N + jj]);
                full = op ? acc - p : acc + p;
                if ((full > 127 || full < -128) && errCycle < 0) begin
                    errCycle = e * ElemCycles + 2 * k + 3;
                end
                acc = wrap8(full);
            end
            expC[e] = acc;
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model
    initial forever begin
        int   rel;
        int   e;
        int   r;
        int   k;
        int   ii;
        int   jj;
        logic expBusy;
        logic expWe;
        logic expDone;
        logic expErr;
        @(negedge CLK);
        rel     = jobActive ? (cyc - jobStart) : -1;
        expBusy = (rel >= 1) && (rel <= JobCycles);
        expWe   = (rel >= ElemCycles) && (rel <= JobCycles) && (rel % ElemCycles == 0);
        expDone = (rel == JobCycles + 1);
        expErr  = (rel >= 1) ? ((errCycle >= 0) && (rel >= errCycle)) : errPrev;
        checkOutput("busy", int'(busy), int'(expBusy));
        checkOutput("c_we", int'(c_we), int'(expWe));
        checkOutput("done", int'(done), int'(expDone));
        checkOutput("error", int'(error), int'(expErr));
        if (expBusy) begin
            e  = (rel - 1) / ElemCycles;
            r  = (rel - 1) % ElemCycles;
            ii = e / N;
            jj = e % N;
            k  = r / 2;
            checkOutput("mac_op", int'(mac_op), int'(jobOp));
            if (r == 2 * N) begin
                checkOutput("c_addr", int'(c_addr), e);
                checkOutput("c_data", int'(c_data), expC[e] & 255);
            end else if (r % 2 == 0) begin
                checkOutput("a_addr", int'(a_addr), ii * N + k);
                checkOutput("b_addr", int'(b_addr), k * N + jj);
            end else begin
                checkOutput("mac_c", int'(mac_c), partial[e][k] & 255);
                checkOutput("mac_a", int'(mac_a), int'(aMem[ii * N + k]));
                checkOutput("mac_b", int'(mac_b), int'(bMem[k * N + jj]));
            end
        end
    end

    // Run one job: start it, optionally pulse start again mid-job with the
    // opposite op, optionally pull reset mid-job, and let it run to idle
    task automatic applyStimulus(input logic op, input int pulseAt, input int resetAt);
        int rel;
        @(posedge CLK);
        #1;
        if (jobActive) begin
            errPrev = (errCycle >= 0);
        end
        computeModel(op);
        jobOp     = op;
        jobStart  = cyc;
        jobActive = 1'b1;
        start     = 1'b1;
        op_sub    = op;
        rel       = 0;
        while (rel < JobCycles + 3) begin
            @(posedge CLK);
            #1;
            rel    = cyc - jobStart;
            start  = (rel == pulseAt);
            op_sub = (rel == pulseAt) ? ~op : 1'($urandom_range(0, 1));
            if (rel == resetAt) begin
                start = 1'b0;
                #1;
                reset     = 1'b0;
                jobActive = 1'b0;
                errPrev   = 1'b0;
                #1;
                checkOutput("rstBusy", int'(busy), 0);
                checkOutput("rstWe", int'(c_we), 0);
                repeat (2) @(posedge CLK);
                #1;
                reset = 1'b1;
                rel   = JobCycles + 3;
            end
        end
        start = 1'b0;
    endtask

    task automatic loadIdentityA();
        for (int n = 0; n < NN; n++) begin
            aMem[n] = (n / N == n % N) ? 8'd1 : 8'd0;
        end
    endtask

    task automatic loadRampB();
        for (int n = 0; n < NN; n++) begin
            bMem[n] = 8'(n);
        end
    endtask

    initial begin
        int weBase;
        for (int n = 0; n < NN; n++) begin
            aMem[n] = '0;
            bMem[n] = '0;
            cMem[n] = '0;
        end

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rstIdleBusy", int'(busy), 0);
        checkOutput("rstIdleDone", int'(done), 0);
        checkOutput("rstIdleWe", int'(c_we), 0);
        checkOutput("rstIdleErr", int'(error), 0);
        checkOutput("rstAaddr", int'(a_addr), 0);
        checkOutput("rstBaddr", int'(b_addr), 0);
        checkOutput("rstCaddr", int'(c_addr), 0);
        checkOutput("rstCdata", int'(c_data), 0);
        reset = 1'b1;
        repeat (2) @(posedge CLK);

        // Identity times ramp
        $display("[TB] identity add job");
        loadIdentityA();
        loadRampB();
        weBase = weCount;
        applyStimulus(1'b0, -1, -1);
        for (int n = 0; n < NN; n++) begin
            checkOutput($sformatf("identC%0d", n), int'(cMem[n]), n);
        end
        checkOutput("identWrites", weCount - weBase, NN);

        // All ones
        $display("[TB] all-ones job");
        for (int n = 0; n < NN; n++) begin
            aMem[n] = 8'd1;
            bMem[n] = 8'd1;
        end
        weBase = weCount;
        applyStimulus(1'b0, -1, -1);
        for (int n = 0; n < NN; n++) begin
            checkOutput($sformatf("onesC%0d", n), int'(cMem[n]), 4);
        end
        checkOutput("onesWrites", weCount - weBase, NN);

        // Subtract mode
        $display("[TB] subtract job");
        loadIdentityA();
        loadRampB();
        applyStimulus(1'b1, -1, -1);
        checkOutput("modelSub1", expC[1] & 255, 255);
        checkOutput("subC1", int'(cMem[1]), 8'hFF);
        checkOutput("subC15", int'(cMem[15]), 8'hF1);

        // Overflow: 16*16 does not fit in 8 bits
        $display("[TB] overflow job");
        for (int n = 0; n < NN; n++) begin
            aMem[n] = 8'd16;
            bMem[n] = 8'd16;
        end
        applyStimulus(1'b0, -1, -1);
        checkOutput("modelErrCycle", errCycle, 3);
        checkOutput("errHeld", int'(error), 1);

        // Identity again, with an ignored start pulse at cycle 20
        $display("[TB] identity job with ignored start");
        loadIdentityA();
        loadRampB();
        applyStimulus(1'b0, 20, -1);
        for (int n = 0; n < NN; n++) begin
            checkOutput($sformatf("ignC%0d", n), int'(cMem[n]), n);
        end
        checkOutput("errCleared", int'(error), 0);

        // Random job abandoned by reset during a write cycle
        $display("[TB] reset mid-job");
        for (int n = 0; n < NN; n++) begin
            aMem[n] = 8'($urandom_range(0, 255));
            bMem[n] = 8'($urandom_range(0, 255));
        end
        applyStimulus(1'($urandom_range(0, 1)), -1, 6 * ElemCycles);
        weBase = weCount;
        repeat (20) @(posedge CLK);
        #1;
        checkOutput("noWritesAfterReset", weCount - weBase, 0);

        // Fresh identity job after reset
        loadIdentityA();
        loadRampB();
        applyStimulus(1'b0, -1, -1);
        for (int n = 0; n < NN; n++) begin
            checkOutput($sformatf("postRstC%0d", n), int'(cMem[n]), n);
        end

        // Randomised jobs, mixing small and full-range operands
        for (int t = 0; t < 6; t++) begin
            $display("[TB] random job %0d", t);
            for (int n = 0; n < NN; n++) begin
                if (t % 2 == 0) begin
                    aMem[n] = 8'($urandom_range(0, 6) - 3);
                    bMem[n] = 8'($urandom_range(0, 6) - 3);
                end else begin
                    aMem[n] = 8'($urandom_range(0, 255));
                    bMem[n] = 8'($urandom_range(0, 255));
                end
            end
            weBase = weCount;
            applyStimulus(1'($urandom_range(0, 1)), (t == 3) ? 70 : -1, -1);
            checkOutput("randWrites", weCount - weBase, NN);
            for (int n = 0; n < NN; n++) begin
                checkOutput($sformatf("randC%0d", n), int'(cMem[n]), expC[n] & 255);
            end
        end

        repeat (3) @(posedge CLK);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
